adpll_lock_ctrl: RTL and testbench
==================================

# adpll_lock_ctrl

Sequencer for the ADPLL channel-acquisition flow. It powers up the DCO and TDC and walks the DCO capacitor banks through three tuning phases: PVT on the large bank, acquisition on the medium bank, tracking on the small bank. It asserts `channel_lock` once tracking settles and watches for loss of lock afterwards. It sits between the top-level mode/enable controls and the DCO/TDC power pins and loop-filter bank enables.

## Interface
- `PHE_W`, 12: width of the signed phase-error input.
- `PWRUP_CYC`, 16: cycles the block waits after power-up before PVT starts.
- `SETTLE_CYC`, 32: consecutive in-threshold cycles required to leave a tuning phase.
- `TH_PVT`, 512: settle threshold (|phase_err|) in PVT.
- `TH_ACQ`, 64: settle threshold in ACQ.
- `TH_TRK`, 8: settle threshold in TRK.
- `TH_LOSS`, 128: loss-of-lock threshold in LOCKED.
- `LOSS_CYC`, 4: consecutive over-threshold cycles that declare loss of lock.
- `TIMEOUT_CYC`, 4096: maximum cycles allowed in any single tuning phase.
- `clk`  in  1  system (reference) clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  ADPLL enable.
- `mode`  in  2  operation mode: PD=0, TEST=1, RX=2, TX=3.
- `phase_err`  in  PHE_W  signed phase error from the phase detector, valid every cycle.
- `dco_pd`  out  1  DCO power-down.
- `tdc_pd`  out  1  TDC power-down.
- `tdc_pd_inj`  out  1  TDC injection power-down.
- `bank_en`  out  3  one-hot integrator enable: [2]=L (PVT), [1]=M (ACQ), [0]=S (TRK); 0 = all banks frozen.
- `channel_lock`  out  1  lock achieved.
- `lock_lost`  out  1  one-cycle pulse on loss of lock.
- `fail`  out  1  a tuning phase timed out.
- `state`  out  3  current state code, for debug.

## Operation
- States and codes: OFF=0, PWRUP=1, PVT=2, ACQ=3, TRK=4, LOCKED=5, TESTM=6, FAIL=7.
- `active` = `en` && `mode`≠PD.
- `absphe`: saturating magnitude of `phase_err`. −2^(PHE_W−1) maps to 2^(PHE_W−1)−1.
- OFF:
  - outputs: `dco_pd`=`tdc_pd`=`tdc_pd_inj`=1, `bank_en`=0.
  - `active` → PWRUP.
- PWRUP:
  - outputs: `dco_pd`=0, `tdc_pd`=`tdc_pd_inj`=(`mode`==TEST), `bank_en`=0.
  - after PWRUP_CYC cycles: → TESTM if `mode`==TEST, else → PVT.
- TESTM: DCO on, TDC off, `bank_en`=0. Holds there.
- PVT, ACQ, TRK:
  - outputs: DCO and TDC on; `bank_en` = 100, 010, 001 respectively.
  - settle counter increments while `absphe` < the phase threshold and clears to 0 otherwise.
  - When the counter reaches SETTLE_CYC the block advances PVT→ACQ→TRK→LOCKED.
  - The settle counter and the timeout counter clear on every state entry.
  - Timeout counter reaching TIMEOUT_CYC → FAIL. If settle and timeout complete in the same cycle, settle wins.
- LOCKED:
  - outputs: `bank_en`=001, `channel_lock`=1.
  - loss counter increments while `absphe` > TH_LOSS and clears otherwise.
  - reaching LOSS_CYC → ACQ, with `lock_lost` pulsed for 1 cycle.
- FAIL: DCO and TDC on, `bank_en`=0, `fail`=1. Only leaves on the abort rules below.
- Abort rules, which take priority over everything except `rst`:
  - `active`=0 in any state → OFF next cycle.
  - `mode` change while in any state other than OFF → PWRUP (power-up count restarts).
  - The previous mode is registered for change detection.
- `rst`: → OFF and all counters cleared.
- Counters: width ⌈log2(max param+1)⌉. They saturate and never wrap.

## Timing
- All outputs are registered and derived from the state register.
- Reset value of every output: `dco_pd`=1, `tdc_pd`=1, `tdc_pd_inj`=1, `bank_en`=0, `channel_lock`=0, `lock_lost`=0, `fail`=0, `state`=0.
- `en` rising at edge N → `state`=PWRUP after edge N+1.
- PVT is entered PWRUP_CYC cycles after PWRUP is entered.
- With `phase_err` continuously in threshold, each tuning phase lasts exactly SETTLE_CYC cycles. `channel_lock` rises 16+3×32 = 112 cycles after PWRUP entry (default parameters).
- `channel_lock` falls in the same cycle `lock_lost` pulses.
- `rst` high mid-operation: outputs return to reset values after the next edge.

## Test plan
- Nominal lock:
  - stimulus: `rst` 1→0, `mode`=RX, `en`=1, `phase_err`=0.
  - response: `bank_en` sequence 100/010/001 with 32 cycles each; `channel_lock`=1 exactly 112 cycles after PWRUP; `fail`=0.
- Settle-counter clearing:
  - stimulus: in ACQ, `phase_err`=+63 for 20 cycles, then one cycle of 64, then 0.
  - response: the counter restarts, so ACQ lasts 20+1+32 = 53 cycles.
- Timeout:
  - stimulus: `phase_err`=600 held through PVT.
  - response: FAIL after 4096 cycles with `fail`=1 and `bank_en`=0. Then `en`=0 → OFF with `fail`=0.
- Loss of lock:
  - stimulus: in LOCKED, `phase_err`=−200 for 3 cycles, then 0 for 1 cycle, then −200 for 4 cycles.
  - response: no action on the first run; on the second run `lock_lost` pulses once, the block enters ACQ, and `channel_lock`=0.
- Boundary value:
  - stimulus: `phase_err`=−2048 in TRK.
  - response: treated as |2047|, never counted as in-threshold.
- Mode/test/reset:
  - stimulus: `mode`=TEST.
  - response: TESTM with `dco_pd`=0 and `tdc_pd`=1.
  - stimulus: switch `mode` TX→RX while LOCKED.
  - response: PWRUP next cycle and `channel_lock`=0.
  - stimulus: assert `rst` in TRK.
  - response: OFF and all reset values.

Source files
------------

// File: rtl/adpll_lock_ctrl.sv
// ----------------------------------------------------------------------------
// adpll_lock_ctrl
//
// Channel-acquisition sequencer for the ADPLL. After enable it powers up the
// DCO/TDC, waits a fixed power-up interval and then walks the DCO capacitor
// banks through three tuning phases (PVT on the large bank, ACQ on the medium
// bank, TRK on the small bank). Each phase is left once |phase_err| has stayed
// under that phase's threshold for SETTLE_CYC consecutive cycles, or aborted
// to FAIL after TIMEOUT_CYC cycles. In LOCKED it watches for LOSS_CYC
// consecutive large errors and falls back to ACQ.
//
// Ports
//   clk            in   reference clock, rising edge
//   rst            in   synchronous active-high reset
//   en_i           in   ADPLL enable
//   mode_i         in   [1:0] PD=0, TEST=1, RX=2, TX=3
//   phase_err_i    in   [PHE_W-1:0] signed phase error, valid every cycle
//   dco_pd_o       out  DCO power-down
//   tdc_pd_o       out  TDC power-down
//   tdc_pd_inj_o   out  TDC injection power-down
//   bank_en_o      out  [2:0] one-hot bank enable, [2]=L [1]=M [0]=S
//   channel_lock_o out  lock achieved
//   lock_lost_o    out  one-cycle pulse on loss of lock
//   fail_o         out  a tuning phase timed out
//   state_o        out  [2:0] current state code (debug)
// ----------------------------------------------------------------------------
module adpll_lock_ctrl #(
    parameter int PHE_W       = 12,
    parameter int PWRUP_CYC   = 16,
    parameter int SETTLE_CYC  = 32,
    parameter int TH_PVT      = 512,
    parameter int TH_ACQ      = 64,
    parameter int TH_TRK      = 8,
    parameter int TH_LOSS     = 128,
    parameter int LOSS_CYC    = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [1:0]              mode_i,
    input  logic signed [PHE_W-1:0] phase_err_i,
    output logic                    dco_pd_o,
    output logic                    tdc_pd_o,
    output logic                    tdc_pd_inj_o,
    output logic [2:0]              bank_en_o,
    output logic                    channel_lock_o,
    output logic                    lock_lost_o,
    output logic                    fail_o,
    output logic [2:0]              state_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] MODE_PD   = 2'd0;
    localparam logic [1:0] MODE_TEST = 2'd1;

    // All counters share one width, sized for the largest count.
    localparam int MAX_AB  = (PWRUP_CYC > SETTLE_CYC) ? PWRUP_CYC : SETTLE_CYC;
    localparam int MAX_CD  = (TIMEOUT_CYC > LOSS_CYC) ? TIMEOUT_CYC : LOSS_CYC;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // A counter holding N-1 in the current cycle means this is the Nth
    // cycle of the condition, so the transition is taken on that edge.
    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_CYC - 1);

    localparam logic [PHE_W-1:0] PHE_MIN = {1'b1, {(PHE_W-1){1'b0}}};
    localparam logic [PHE_W-1:0] PHE_MAX = {1'b0, {(PHE_W-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_PVT    = 3'd2,
        ST_ACQ    = 3'd3,
        ST_TRK    = 3'd4,
        ST_LOCKED = 3'd5,
        ST_TESTM  = 3'd6,
        ST_FAIL   = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       mode_prev_q;
    logic [CNT_W-1:0] tmo_q, tmo_d;        // time-in-state (power-up and timeout)
    logic [CNT_W-1:0] settle_q, settle_d;  // consecutive in-threshold cycles
    logic [CNT_W-1:0] loss_q, loss_d;      // consecutive over-loss-threshold cycles

    logic       dco_pd_q, dco_pd_d;
    logic       tdc_pd_q, tdc_pd_d;
    logic       tdc_pd_inj_q, tdc_pd_inj_d;
    logic [2:0] bank_en_q, bank_en_d;
    logic       channel_lock_q, channel_lock_d;
    logic       lock_lost_q, lock_lost_d;
    logic       fail_q, fail_d;

    // ------------------------------------------------------------------
    // Phase-error magnitude, saturating so the most negative code does not
    // alias to itself and look small.
    // ------------------------------------------------------------------
    logic [PHE_W-1:0] phe_u;
    logic [PHE_W-1:0] absphe;

    assign phe_u = phase_err_i;

    always_comb begin
        absphe = phe_u;
        if (phe_u == PHE_MIN) begin
            absphe = PHE_MAX;
        end else if (phe_u[PHE_W-1]) begin
            absphe = ~phe_u + PHE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-bank settle comparisons, indexed like bank_en: [2]=PVT threshold,
    // [1]=ACQ threshold, [0]=TRK threshold. The active tuning bank selects
    // which comparison counts.
    // ------------------------------------------------------------------
    logic [2:0] below_th;
    logic [2:0] tune_sel;
    logic       in_th;
    logic       over_loss;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_th
            localparam int TH = (gi == 2) ? TH_PVT : ((gi == 1) ? TH_ACQ : TH_TRK);
            assign below_th[gi] = (absphe < PHE_W'(TH));
        end
    endgenerate

    always_comb begin
        tune_sel = 3'b000;
        case (state_q)
            ST_PVT:  tune_sel = 3'b100;
            ST_ACQ:  tune_sel = 3'b010;
            ST_TRK:  tune_sel = 3'b001;
            default: tune_sel = 3'b000;
        endcase
    end

    assign in_th     = |(tune_sel & below_th);
    assign over_loss = (absphe > PHE_W'(TH_LOSS));

    // ------------------------------------------------------------------
    // Transition conditions
    // ------------------------------------------------------------------
    logic active;
    logic mode_chg;
    logic pwrup_done;
    logic settle_done;
    logic tmo_done;
    logic loss_done;

    assign active      = en_i && (mode_i != MODE_PD);
    assign mode_chg    = (state_q != ST_OFF) && (mode_i != mode_prev_q);
    assign pwrup_done  = (tmo_q >= PWRUP_LAST);
    assign settle_done = in_th && (settle_q >= SETTLE_LAST);
    assign tmo_done    = (tmo_q >= TIMEOUT_LAST);
    assign loss_done   = over_loss && (loss_q >= LOSS_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic restart;  // mode change re-enters PWRUP even when already there

    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        lock_lost_d = 1'b0;
        if (!active) begin
            state_d = ST_OFF;
        end else if (mode_chg) begin
            state_d = ST_PWRUP;
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_PWRUP;
                ST_PWRUP: begin
                    if (pwrup_done) begin
                        state_d = (mode_i == MODE_TEST) ? ST_TESTM : ST_PVT;
                    end
                end
                // Settle is checked first so it wins a tie with timeout.
                ST_PVT: begin
                    if (settle_done)   state_d = ST_ACQ;
                    else if (tmo_done) state_d = ST_FAIL;
                end
                ST_ACQ: begin
                    if (settle_done)   state_d = ST_TRK;
                    else if (tmo_done) state_d = ST_FAIL;
                end
                ST_TRK: begin
                    if (settle_done)   state_d = ST_LOCKED;
                    else if (tmo_done) state_d = ST_FAIL;
                end
                ST_LOCKED: begin
                    if (loss_done) begin
                        state_d     = ST_ACQ;
                        lock_lost_d = 1'b1;
                    end
                end
                ST_TESTM: state_d = ST_TESTM;
                ST_FAIL:  state_d = ST_FAIL;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counter next values: all clear on any state entry, otherwise count
    // with saturation.
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic enter;
    assign enter = restart || (state_d != state_q);

    always_comb begin
        tmo_d    = '0;
        settle_d = '0;
        loss_d   = '0;
        if (!enter) begin
            tmo_d    = sat_inc(tmo_q);
            settle_d = in_th ? sat_inc(settle_q) : '0;
            loss_d   = over_loss ? sat_inc(loss_q) : '0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs always
    // line up with state_q.
    // ------------------------------------------------------------------
    always_comb begin
        dco_pd_d       = 1'b1;
        tdc_pd_d       = 1'b1;
        tdc_pd_inj_d   = 1'b1;
        bank_en_d      = 3'b000;
        channel_lock_d = 1'b0;
        fail_d         = 1'b0;
        case (state_d)
            ST_OFF: ;
            ST_PWRUP: begin
                dco_pd_d     = 1'b0;
                tdc_pd_d     = (mode_i == MODE_TEST);
                tdc_pd_inj_d = (mode_i == MODE_TEST);
            end
            ST_TESTM: dco_pd_d = 1'b0;
            ST_PVT, ST_ACQ, ST_TRK, ST_LOCKED: begin
                dco_pd_d     = 1'b0;
                tdc_pd_d     = 1'b0;
                tdc_pd_inj_d = 1'b0;
                case (state_d)
                    ST_PVT:  bank_en_d = 3'b100;
                    ST_ACQ:  bank_en_d = 3'b010;
                    default: bank_en_d = 3'b001;
                endcase
                channel_lock_d = (state_d == ST_LOCKED);
            end
            ST_FAIL: begin
                dco_pd_d     = 1'b0;
                tdc_pd_d     = 1'b0;
                tdc_pd_inj_d = 1'b0;
                fail_d       = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_OFF;
            mode_prev_q    <= MODE_PD;
            tmo_q          <= '0;
            settle_q       <= '0;
            loss_q         <= '0;
            dco_pd_q       <= 1'b1;
            tdc_pd_q       <= 1'b1;
            tdc_pd_inj_q   <= 1'b1;
            bank_en_q      <= 3'b000;
            channel_lock_q <= 1'b0;
            lock_lost_q    <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_prev_q    <= mode_i;
            tmo_q          <= tmo_d;
            settle_q       <= settle_d;
            loss_q         <= loss_d;
            dco_pd_q       <= dco_pd_d;
            tdc_pd_q       <= tdc_pd_d;
            tdc_pd_inj_q   <= tdc_pd_inj_d;
            bank_en_q      <= bank_en_d;
            channel_lock_q <= channel_lock_d;
            lock_lost_q    <= lock_lost_d;
            fail_q         <= fail_d;
        end
    end

    assign dco_pd_o       = dco_pd_q;
    assign tdc_pd_o       = tdc_pd_q;
    assign tdc_pd_inj_o   = tdc_pd_inj_q;
    assign bank_en_o      = bank_en_q;
    assign channel_lock_o = channel_lock_q;
    assign lock_lost_o    = lock_lost_q;
    assign fail_o         = fail_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for adpll_lock_ctrl. The stimulus process drives directed vectors and,
// for every output change it expects, pushes {edge number, output vector} into
// a queue. A monitor samples on the falling edge; each time the packed output
// vector changes it pops the next expectation and checks both the edge at
// which the change happened and the new vector.
// ----------------------------------------------------------------------------
module tb_adpll_lock_ctrl;

    localparam int S_OFF = 0, S_PWRUP = 1, S_PVT = 2, S_ACQ = 3,
                   S_TRK = 4, S_LOCKED = 5, S_TESTM = 6, S_FAIL = 7;

    logic               clk;
    logic               rst;
    logic               en;
    logic [1:0]         mode;
    logic signed [11:0] phase_err;
    logic               dco_pd, tdc_pd, tdc_pd_inj;
    logic [2:0]         bank_en;
    logic               channel_lock, lock_lost, fail;
    logic [2:0]         state;

    adpll_lock_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .mode_i         (mode),
        .phase_err_i    (phase_err),
        .dco_pd_o       (dco_pd),
        .tdc_pd_o       (tdc_pd),
        .tdc_pd_inj_o   (tdc_pd_inj),
        .bank_en_o      (bank_en),
        .channel_lock_o (channel_lock),
        .lock_lost_o    (lock_lost),
        .fail_o         (fail),
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [11:0] vec;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Expected packed outputs {state, dco_pd, tdc_pd, tdc_pd_inj, bank_en,
    // channel_lock, lock_lost, fail}, written out from the state table.
    function automatic logic [11:0] expv(input int st, input bit tst, input bit lost);
        logic [2:0] s;
        logic       d, t, i, lk, fl;
        logic [2:0] b;
        s = 3'(st);
        d = 1'b1; t = 1'b1; i = 1'b1; b = 3'b000; lk = 1'b0; fl = 1'b0;
        case (st)
            S_PWRUP:  begin d = 1'b0; t = tst; i = tst; end
            S_TESTM:  begin d = 1'b0; end
            S_PVT:    begin d = 1'b0; t = 1'b0; i = 1'b0; b = 3'b100; end
            S_ACQ:    begin d = 1'b0; t = 1'b0; i = 1'b0; b = 3'b010; end
            S_TRK:    begin d = 1'b0; t = 1'b0; i = 1'b0; b = 3'b001; end
            S_LOCKED: begin d = 1'b0; t = 1'b0; i = 1'b0; b = 3'b001; lk = 1'b1; end
            S_FAIL:   begin d = 1'b0; t = 1'b0; i = 1'b0; fl = 1'b1; end
            default:  ;
        endcase
        return {s, d, t, i, b, lk, lost, fl};
    endfunction

    task automatic push_exp(input int dt, input logic [11:0] v, input string nm);
        exp_t e;
        e.at   = cyc + dt;
        e.vec  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per observed output change.
    logic [11:0] prev_vec = 12'hFFF;
    always @(negedge clk) begin
        logic [11:0] cur;
        exp_t        e;
        cur = {state, dco_pd, tdc_pd, tdc_pd_inj, bank_en, channel_lock, lock_lost, fail};
        if (cur !== prev_vec) begin
            prev_vec = cur;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: edge=%0d got vec=%03h, required no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.at != cyc || e.vec !== cur) begin
                    n_bad++;
                    $display("FAIL %s: edge=%0d vec=%03h, required edge=%0d vec=%03h",
                             e.name, cyc, cur, e.at, e.vec);
                end else begin
                    $display("ok   %s: edge=%0d vec=%03h", e.name, cyc, cur);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 2'd0;
        phase_err = '0;
        push_exp(1, expv(S_OFF, 0, 0), "reset_values");
        tick(3);
        rst = 1'b0;
        tick(2);

        // Nominal lock in RX: 16 cycles power-up, 32 per tuning phase.
        mode = 2'd2;
        en   = 1'b1;
        push_exp(1,   expv(S_PWRUP, 0, 0),  "nom_pwrup");
        push_exp(17,  expv(S_PVT, 0, 0),    "nom_pvt");
        push_exp(49,  expv(S_ACQ, 0, 0),    "nom_acq");
        push_exp(81,  expv(S_TRK, 0, 0),    "nom_trk");
        push_exp(113, expv(S_LOCKED, 0, 0), "nom_locked_112");
        tick(113);

        // Loss of lock: a run of 3 is ignored, the run of 4 trips it.
        push_exp(8, expv(S_ACQ, 0, 1), "loss_pulse");
        push_exp(9, expv(S_ACQ, 0, 0), "loss_pulse_end");
        phase_err = -12'sd200; tick(3);
        phase_err = 12'sd0;    tick(1);
        phase_err = -12'sd200; tick(4);

        // ACQ settle restart: 20 in-threshold, one at threshold, then 32.
        push_exp(53, expv(S_TRK, 0, 0), "acq_53_cycles");
        phase_err = 12'sd63; tick(20);
        phase_err = 12'sd64; tick(1);
        phase_err = 12'sd0;  tick(32);

        // Most negative code must never count as in-threshold in TRK.
        push_exp(72, expv(S_LOCKED, 0, 0), "trk_min_code");
        phase_err = -12'sd2048; tick(40);
        phase_err = 12'sd0;     tick(32);

        // Mode change RX -> TX while locked: restart, then relock in TX.
        mode = 2'd3;
        push_exp(1,   expv(S_PWRUP, 0, 0),  "rx2tx_pwrup");
        push_exp(17,  expv(S_PVT, 0, 0),    "tx_pvt");
        push_exp(49,  expv(S_ACQ, 0, 0),    "tx_acq");
        push_exp(81,  expv(S_TRK, 0, 0),    "tx_trk");
        push_exp(113, expv(S_LOCKED, 0, 0), "tx_locked");
        tick(113);

        // Mode change TX -> RX while locked, run on into TRK.
        mode = 2'd2;
        push_exp(1,  expv(S_PWRUP, 0, 0), "tx2rx_pwrup");
        push_exp(17, expv(S_PVT, 0, 0),   "rx_pvt");
        push_exp(49, expv(S_ACQ, 0, 0),   "rx_acq");
        push_exp(81, expv(S_TRK, 0, 0),   "rx_trk");
        tick(81);

        // Reset in TRK, then restart from OFF once released.
        rst = 1'b1;
        push_exp(1, expv(S_OFF, 0, 0), "rst_in_trk");
        tick(3);
        rst = 1'b0;
        push_exp(1, expv(S_PWRUP, 0, 0), "post_rst_pwrup");
        tick(1);

        // Switch to TEST inside PWRUP: power-up count restarts, ends in TESTM.
        mode = 2'd1;
        push_exp(1,  expv(S_PWRUP, 1, 0), "test_pwrup");
        push_exp(17, expv(S_TESTM, 0, 0), "testm");
        tick(17);
        tick(20);

        // Timeout in PVT with a large error, then disable.
        mode      = 2'd2;
        phase_err = 12'sd600;
        push_exp(1,         expv(S_PWRUP, 0, 0), "tmo_pwrup");
        push_exp(17,        expv(S_PVT, 0, 0),   "tmo_pvt");
        push_exp(17 + 4096, expv(S_FAIL, 0, 0),  "tmo_fail");
        tick(17 + 4096);
        en = 1'b0;
        push_exp(1, expv(S_OFF, 0, 0), "fail_to_off");
        tick(1);
        tick(5);

        // Every expected change must have been seen.
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end else begin
            $display("ok   drain: 0 expectations left");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
